alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  Issue stage directly upstream of the 32-bit ALU: accepts decoded instructions over a valid/ready handshake.
//  Maps opcode/funct to the 4-bit ALU_control code and selects operands (register, sign- or zero-extended immediate).
//  Forwards a write-back result onto matching source operands, then presents registered src1/src2/ALU_control to the ALU.
//  A 2-entry skid buffer gives full throughput under downstream backpressure.
// PARAMETERS
//  DW     32  operand/result width
//  RW      5  register index width
//  OPW     6  opcode and funct field width
// PORTS
//  clk_i        in   1    clock, rising edge
//  rst_i        in   1    synchronous reset, active-high
//  in_valid     in   1    upstream instruction valid
//  in_ready     out  1    stage can accept (= skid entry empty)
//  in_op        in   6    opcode
//  in_funct     in   6    funct (R-type only)
//  in_rs_idx    in   5    rs index
//  in_rt_idx    in   5    rt index
//  in_rd_idx    in   5    destination index, passed through
//  in_rs_data   in   32   rs register value
//  in_rt_data   in   32   rt register value
//  in_imm       in   16   immediate
//  fwd_valid    in   1    write-back result valid this cycle
//  fwd_rd       in   5    write-back destination index
//  fwd_data     in   32   write-back value
//  out_valid    out  1    ALU operands valid
//  out_ready    in   1    downstream accepts
//  src1         out  32   ALU source 1
//  src2         out  32   ALU source 2
//  alu_control  out  4    ALU_control code
//  out_rd       out  5    destination index
//  out_illegal  out  1    undecodable op/funct
// BEHAVIOUR
//  Reset (rst_i=1 at posedge): both entries invalid; out_valid=0, src1/src2/alu_control/out_rd/out_illegal=0.
//   in_ready=0 during reset, 1 on the first cycle after it.
//  Transfer happens when valid&&ready, at the same edge. Latency: accepted at edge N -> out_valid at N+1.
//   One transfer per cycle sustained while out_ready=1.
//  Output register: loads when it is empty or out_ready=1. Source is the skid entry if full, else the input.
//  Skid: in_ready registered = !skid_full. An input accepted while out_valid && !out_ready goes to skid.
//   skid_full clears when the output drains it.
//  Outputs hold stable while out_valid && !out_ready. A held entry is never dropped or duplicated.
//  Decode (ALU_control): R-type op=000000 by funct:
//   100100 AND=0000, 100101 OR=0001, 100000 ADD=0010, 100010 SUB=0110, 100111 NOR=1100, 101010 SLT=0111.
//   Operands src1=rs, src2=rt.
//  I-type, src1=rs:
//   addi 001000 ADD, sign-ext imm;  slti 001010 SLT, sign-ext;
//   andi 001100 AND, zero-ext;      ori 001101 OR, zero-ext;
//   beq 000100 SUB, src2=rt.
//  Any other op/funct: out_illegal=1, alu_control=0010, src1=rs, src2=rt; handshake proceeds normally.
//  Forwarding: applied at acceptance (input capture), not at skid drain.
//   rs/rt data := fwd_data if fwd_valid && fwd_rd!=0 && fwd_rd==idx.
//   Index 0 is never forwarded. rs and rt may both match; both take fwd_data.
//   Immediate-operand instructions ignore an rt match.
//  Skid-held entries are not re-forwarded. The producer must not issue a dependent instruction during a stall.
//  Reset mid-operation: any held/skid entry is discarded and no transfer completes at that edge.
// STRUCTURE
//  Shared package alu_defs_pkg:
//   ALU_control localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_NOR, ALU_SLT);
//   opcode/funct constants;
//   issue-entry packed struct {src1, src2, ctrl, rd, illegal}.
//  One sub-module alu_op_decode: combinational op/funct -> ctrl, imm_sel, sext, illegal.
//  Skid buffer and forwarding mux stay inline.
// TESTING
//  1 Reset: hold rst_i 2 cycles with in_valid=1 -> out_valid=0, outputs 0, in_ready=0; cycle after -> in_ready=1.
//  2 Decode: add/sub/and/or/nor/slt R-type plus addi imm=16'hFFFF, ori imm=16'hFFFF, rs=32'h10.
//     -> ctrl 0010/0110/0000/0001/1100/0111; addi src2=32'hFFFFFFFF, ori src2=32'h0000FFFF.
//  3 Forwarding: fwd rd=5 data=32'hDEAD_BEEF, rs=rt=5 -> src1=src2=32'hDEADBEEF; same with rd=0 -> register values.
//  4 Backpressure: stream 8 instructions, out_ready=0 for 3 cycles mid-stream -> in_ready=0 after 2 buffered.
//     All 8 emerge in order, none lost or duplicated, outputs stable while stalled.
//  5 Illegal: op=000000 funct=000001 -> out_illegal=1, alu_control=0010, out_valid=1 next cycle.
//  6 Reset mid-stall: skid full, assert rst_i -> out_valid=0 next cycle, nothing emitted afterwards.

Source files
------------

// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue stage: field widths, ALU_control codes,
// opcode/funct encodings and the issue-entry record carried through the skid buffer.
package alu_defs_pkg;

  localparam int DW  = 32;
  localparam int RW  = 5;
  localparam int OPW = 6;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPW-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OPW-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPW-1:0] OP_ORI   = 6'b001101;

  localparam logic [OPW-1:0] FN_ADD = 6'b100000;
  localparam logic [OPW-1:0] FN_SUB = 6'b100010;
  localparam logic [OPW-1:0] FN_AND = 6'b100100;
  localparam logic [OPW-1:0] FN_OR  = 6'b100101;
  localparam logic [OPW-1:0] FN_NOR = 6'b100111;
  localparam logic [OPW-1:0] FN_SLT = 6'b101010;

  typedef struct packed {
    logic [DW-1:0] src1;
    logic [DW-1:0] src2;
    logic [3:0]    ctrl;
    logic [RW-1:0] rd;
    logic          illegal;
  } issue_entry_t;

  function automatic logic [DW-1:0] extendImm(input logic [15:0] imm, input logic sext);
    return sext ? {{(DW-16){imm[15]}}, imm} : {{(DW-16){1'b0}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Bundle of the upstream handshake, write-back forwarding and ALU-side handshake
// signals; slave is the issue stage, master is whoever drives it.
interface alu_issue_if;
  import alu_defs_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] in_op;
  logic [OPW-1:0] in_funct;
  logic [RW-1:0]  in_rs_idx;
  logic [RW-1:0]  in_rt_idx;
  logic [RW-1:0]  in_rd_idx;
  logic [DW-1:0]  in_rs_data;
  logic [DW-1:0]  in_rt_data;
  logic [15:0]    in_imm;

  logic           fwd_valid;
  logic [RW-1:0]  fwd_rd;
  logic [DW-1:0]  fwd_data;

  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  src1;
  logic [DW-1:0]  src2;
  logic [3:0]     alu_control;
  logic [RW-1:0]  out_rd;
  logic           out_illegal;

  modport slave (
    input  in_valid, in_op, in_funct, in_rs_idx, in_rt_idx, in_rd_idx,
           in_rs_data, in_rt_data, in_imm,
    input  fwd_valid, fwd_rd, fwd_data,
    input  out_ready,
    output in_ready, out_valid, src1, src2, alu_control, out_rd, out_illegal
  );

  modport master (
    output in_valid, in_op, in_funct, in_rs_idx, in_rt_idx, in_rd_idx,
           in_rs_data, in_rt_data, in_imm,
    output fwd_valid, fwd_rd, fwd_data,
    output out_ready,
    input  in_ready, out_valid, src1, src2, alu_control, out_rd, out_illegal
  );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational opcode/funct decode into ALU_control plus immediate-operand selection.
// Undecodable encodings fall back to ADD on register operands and raise o_illegal.
module alu_op_decode
  import alu_defs_pkg::*;
(
  input  logic [OPW-1:0] i_op,
  input  logic [OPW-1:0] i_funct,
  output logic [3:0]     o_ctrl,
  output logic           o_imm_sel,
  output logic           o_sext,
  output logic           o_illegal
);

  always_comb begin
    o_ctrl    = ALU_ADD;
    o_imm_sel = 1'b0;
    o_sext    = 1'b0;
    o_illegal = 1'b0;
    case (i_op)
      OP_RTYPE: begin
        case (i_funct)
          FN_AND:  o_ctrl = ALU_AND;
          FN_OR:   o_ctrl = ALU_OR;
          FN_ADD:  o_ctrl = ALU_ADD;
          FN_SUB:  o_ctrl = ALU_SUB;
          FN_NOR:  o_ctrl = ALU_NOR;
          FN_SLT:  o_ctrl = ALU_SLT;
          default: o_illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        o_ctrl    = ALU_ADD;
        o_imm_sel = 1'b1;
        o_sext    = 1'b1;
      end
      OP_SLTI: begin
        o_ctrl    = ALU_SLT;
        o_imm_sel = 1'b1;
        o_sext    = 1'b1;
      end
      OP_ANDI: begin
        o_ctrl    = ALU_AND;
        o_imm_sel = 1'b1;
      end
      OP_ORI: begin
        o_ctrl    = ALU_OR;
        o_imm_sel = 1'b1;
      end
      // beq compares by subtraction, so both operands come from registers
      OP_BEQ:  o_ctrl = ALU_SUB;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the ALU: decode, operand select and write-back forwarding at
// capture, then a registered output slot backed by one skid entry for full throughput.
module alu_issue_stage
  import alu_defs_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  alu_issue_if.slave  bus
);

  logic [3:0]    w_ctrl;
  logic          w_immSel;
  logic          w_sext;
  logic          w_illegal;
  logic          w_rsFwd;
  logic          w_rtFwd;
  logic [DW-1:0] w_rsData;
  logic [DW-1:0] w_rtData;
  issue_entry_t  w_capture;
  logic          w_accept;
  logic          w_outLoad;
  logic          w_skidFullNext;

  issue_entry_t  r_out;
  issue_entry_t  r_skid;
  logic          r_outValid;
  logic          r_skidFull;
  logic          r_inReady;

  alu_op_decode u_decode (
    .i_op      (bus.in_op),
    .i_funct   (bus.in_funct),
    .o_ctrl    (w_ctrl),
    .o_imm_sel (w_immSel),
    .o_sext    (w_sext),
    .o_illegal (w_illegal)
  );

  // Register 0 is hard-wired, so a write-back targeting it is never forwarded
  always_comb begin
    w_rsFwd  = bus.fwd_valid && (bus.fwd_rd != '0) && (bus.fwd_rd == bus.in_rs_idx);
    w_rtFwd  = bus.fwd_valid && (bus.fwd_rd != '0) && (bus.fwd_rd == bus.in_rt_idx);
    w_rsData = w_rsFwd ? bus.fwd_data : bus.in_rs_data;
    w_rtData = w_rtFwd ? bus.fwd_data : bus.in_rt_data;

    w_capture.src1    = w_rsData;
    w_capture.src2    = w_immSel ? extendImm(bus.in_imm, w_sext) : w_rtData;
    w_capture.ctrl    = w_ctrl;
    w_capture.rd      = bus.in_rd_idx;
    w_capture.illegal = w_illegal;
  end

  // The skid entry fills only when an input arrives while the output slot is held
  always_comb begin
    w_accept       = bus.in_valid && r_inReady;
    w_outLoad      = !r_outValid || bus.out_ready;
    w_skidFullNext = w_outLoad ? 1'b0 : (r_skidFull || w_accept);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out      <= '0;
      r_skid     <= '0;
      r_outValid <= 1'b0;
      r_skidFull <= 1'b0;
      r_inReady  <= 1'b0;
    end else begin
      r_skidFull <= w_skidFullNext;
      r_inReady  <= !w_skidFullNext;
      if (w_outLoad) begin
        if (r_skidFull) begin
          r_out      <= r_skid;
          r_outValid <= 1'b1;
        end else if (w_accept) begin
          r_out      <= w_capture;
          r_outValid <= 1'b1;
        end else begin
          r_outValid <= 1'b0;
        end
      end else if (w_accept) begin
        r_skid <= w_capture;
      end
    end
  end

  assign bus.in_ready    = r_inReady;
  assign bus.out_valid   = r_outValid;
  assign bus.src1        = r_out.src1;
  assign bus.src2        = r_out.src2;
  assign bus.alu_control = r_out.ctrl;
  assign bus.out_rd      = r_out.rd;
  assign bus.out_illegal = r_out.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: accepted instructions push a reference-model
// result, and an independent monitor pops and compares whatever the stage presents.
module tb_alu_issue_stage;
  import alu_defs_pkg::*;

  logic clk = 1'b0;
  logic rst;
  alu_issue_if bus();

  alu_issue_stage dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int errors   = 0;
  int popCount = 0;
  bit streamDone;
  issue_entry_t expQ[$];

  logic [5:0] opTable [0:7] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h04};
  logic [5:0] fnTable [0:5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
  logic [3:0] ctrlTable [0:5] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};

  // Reference behaviour: forward, then pick the operation and operands by mnemonic
  function automatic issue_entry_t modelIssue(
    input logic [5:0] op, input logic [5:0] funct,
    input logic [4:0] rsIdx, input logic [4:0] rtIdx, input logic [4:0] rdIdx,
    input logic [31:0] rsData, input logic [31:0] rtData, input logic [15:0] imm,
    input logic fwdV, input logic [4:0] fwdRd, input logic [31:0] fwdData);
    issue_entry_t e;
    logic [31:0] a, b, simm, zimm;
    a    = (fwdV && fwdRd != 5'd0 && fwdRd == rsIdx) ? fwdData : rsData;
    b    = (fwdV && fwdRd != 5'd0 && fwdRd == rtIdx) ? fwdData : rtData;
    simm = {{16{imm[15]}}, imm};
    zimm = {16'h0000, imm};
    e = '{src1: a, src2: b, ctrl: 4'b0010, rd: rdIdx, illegal: 1'b0};
    if (op == 6'h00) begin
      case (funct)
        6'h24:   e.ctrl = 4'b0000;
        6'h25:   e.ctrl = 4'b0001;
        6'h20:   e.ctrl = 4'b0010;
        6'h22:   e.ctrl = 4'b0110;
        6'h27:   e.ctrl = 4'b1100;
        6'h2A:   e.ctrl = 4'b0111;
        default: e.illegal = 1'b1;
      endcase
    end else begin
      case (op)
        6'h08:   begin e.ctrl = 4'b0010; e.src2 = simm; end
        6'h0A:   begin e.ctrl = 4'b0111; e.src2 = simm; end
        6'h0C:   begin e.ctrl = 4'b0000; e.src2 = zimm; end
        6'h0D:   begin e.ctrl = 4'b0001; e.src2 = zimm; end
        6'h04:   e.ctrl = 4'b0110;
        default: e.illegal = 1'b1;
      endcase
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkEntry(input issue_entry_t exp);
    issue_entry_t act;
    act = '{src1: bus.src1, src2: bus.src2, ctrl: bus.alu_control, rd: bus.out_rd, illegal: bus.out_illegal};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL scoreboard @%0t: got src1=%h src2=%h ctrl=%b rd=%0d ill=%b, expected src1=%h src2=%h ctrl=%b rd=%0d ill=%b",
               $time, act.src1, act.src2, act.ctrl, act.rd, act.illegal,
               exp.src1, exp.src2, exp.ctrl, exp.rd, exp.illegal);
    end
  endtask

  // Presents one instruction and holds it until accepted; returns just after the accepting edge
  task automatic applyStimulus(
    input logic [5:0] op, input logic [5:0] funct,
    input logic [4:0] rsIdx, input logic [4:0] rtIdx, input logic [4:0] rdIdx,
    input logic [31:0] rsData, input logic [31:0] rtData, input logic [15:0] imm,
    input logic fwdV, input logic [4:0] fwdRd, input logic [31:0] fwdData);
    bit done;
    done = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_op      = op;
    bus.in_funct   = funct;
    bus.in_rs_idx  = rsIdx;
    bus.in_rt_idx  = rtIdx;
    bus.in_rd_idx  = rdIdx;
    bus.in_rs_data = rsData;
    bus.in_rt_data = rtData;
    bus.in_imm     = imm;
    bus.fwd_valid  = fwdV;
    bus.fwd_rd     = fwdRd;
    bus.fwd_data   = fwdData;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1 && rst === 1'b0) begin
        expQ.push_back(modelIssue(op, funct, rsIdx, rtIdx, rdIdx, rsData, rtData, imm, fwdV, fwdRd, fwdData));
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept timeout: got in_ready=%b, expected 1", bus.in_ready);
    end
    bus.in_valid  = 1'b0;
    bus.fwd_valid = 1'b0;
  endtask

  task automatic sendRandom();
    logic [5:0] op, funct;
    op    = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : opTable[$urandom_range(0, 7)];
    funct = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : fnTable[$urandom_range(0, 5)];
    applyStimulus(op, funct, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom),
                  $urandom, $urandom, 16'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), $urandom);
  endtask

  // Monitor: every presented output is compared against the oldest outstanding expectation
  initial begin
    forever begin
      @(negedge clk); #1;
      if (rst === 1'b0 && bus.out_valid === 1'b1) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected output: got out_valid=1 src1=%h, expected no output", bus.src1);
        end else begin
          checkEntry(expQ[0]);
          if (bus.out_ready === 1'b1) begin
            void'(expQ.pop_front());
            popCount++;
          end
        end
      end
    end
  end

  initial begin
    #300000;
    errors++;
    checks++;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int popStart;
    rst            = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_op      = '0;
    bus.in_funct   = '0;
    bus.in_rs_idx  = '0;
    bus.in_rt_idx  = '0;
    bus.in_rd_idx  = '0;
    bus.in_rs_data = '0;
    bus.in_rt_data = '0;
    bus.in_imm     = '0;
    bus.fwd_valid  = 1'b0;
    bus.fwd_rd     = '0;
    bus.fwd_data   = '0;
    bus.out_ready  = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset src1", bus.src1, 32'd0);
    checkOutput("reset src2", bus.src2, 32'd0);
    checkOutput("reset alu_control", 32'(bus.alu_control), 32'd0);
    checkOutput("reset out_rd", 32'(bus.out_rd), 32'd0);
    checkOutput("reset out_illegal", 32'(bus.out_illegal), 32'd0);
    checkOutput("reset in_ready", 32'(bus.in_ready), 32'd0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("post-reset in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("post-reset out_valid", 32'(bus.out_valid), 32'd0);

    $display("[TB] decode");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(6'h00, fnTable[i], 5'd1, 5'd2, 5'd3, 32'h10, 32'h20 + i, 16'h0, 1'b0, 5'd0, 32'h0);
      checkOutput("decode R-type ctrl", 32'(bus.alu_control), 32'(ctrlTable[i]));
    end
    applyStimulus(6'h08, 6'h00, 5'd1, 5'd2, 5'd4, 32'h10, 32'h55, 16'hFFFF, 1'b0, 5'd0, 32'h0);
    checkOutput("addi src1", bus.src1, 32'h0000_0010);
    checkOutput("addi src2", bus.src2, 32'hFFFF_FFFF);
    checkOutput("addi ctrl", 32'(bus.alu_control), 32'b0010);
    applyStimulus(6'h0D, 6'h00, 5'd1, 5'd2, 5'd4, 32'h10, 32'h55, 16'hFFFF, 1'b0, 5'd0, 32'h0);
    checkOutput("ori src2", bus.src2, 32'h0000_FFFF);
    checkOutput("ori ctrl", 32'(bus.alu_control), 32'b0001);

    $display("[TB] forwarding");
    applyStimulus(6'h00, 6'h20, 5'd5, 5'd5, 5'd6, 32'h1111, 32'h2222, 16'h0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    checkOutput("fwd src1", bus.src1, 32'hDEAD_BEEF);
    checkOutput("fwd src2", bus.src2, 32'hDEAD_BEEF);
    applyStimulus(6'h00, 6'h20, 5'd0, 5'd0, 5'd6, 32'h1111, 32'h2222, 16'h0, 1'b1, 5'd0, 32'hDEAD_BEEF);
    checkOutput("fwd r0 src1", bus.src1, 32'h0000_1111);
    checkOutput("fwd r0 src2", bus.src2, 32'h0000_2222);
    applyStimulus(6'h08, 6'h00, 5'd7, 5'd7, 5'd6, 32'h1111, 32'h2222, 16'h0003, 1'b1, 5'd7, 32'hCAFE_0000);
    checkOutput("fwd imm src1", bus.src1, 32'hCAFE_0000);
    checkOutput("fwd imm src2", bus.src2, 32'h0000_0003);

    $display("[TB] illegal");
    applyStimulus(6'h00, 6'h01, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 16'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("illegal out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("illegal flag", 32'(bus.out_illegal), 32'd1);
    checkOutput("illegal ctrl", 32'(bus.alu_control), 32'b0010);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] backpressure");
    popStart = popCount;
    fork
      begin
        for (int k = 0; k < 8; k++) sendRandom();
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("stall in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    for (int c = 0; c < 20 && expQ.size() != 0; c++) @(posedge clk);
    #1;
    checkOutput("backpressure count", 32'(popCount - popStart), 32'd8);
    checkOutput("backpressure drained", 32'(expQ.size()), 32'd0);

    $display("[TB] random");
    streamDone = 1'b0;
    fork
      begin
        for (int k = 0; k < 60; k++) sendRandom();
        streamDone = 1'b1;
      end
      begin
        while (!streamDone) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    for (int c = 0; c < 20 && expQ.size() != 0; c++) @(posedge clk);
    #1;
    checkOutput("random drained", 32'(expQ.size()), 32'd0);

    $display("[TB] reset mid-stall");
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    applyStimulus(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'hA, 32'hB, 16'h0, 1'b0, 5'd0, 32'h0);
    applyStimulus(6'h00, 6'h22, 5'd1, 5'd2, 5'd4, 32'hC, 32'hD, 16'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("skid full in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    expQ.delete();
    @(posedge clk); #1;
    checkOutput("mid-reset out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("mid-reset in_ready", 32'(bus.in_ready), 32'd0);
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("after reset out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("after reset in_ready", 32'(bus.in_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
